// File: rtl/uart_tx_word.sv
// Word-wide 8N1 UART transmitter: sends NBYTES bytes LSB byte first, pausing
// between bytes while XOFF is in effect.
module uart_tx_word #(
    parameter int CLKS_PER_BIT = 104,
    parameter int NBYTES       = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [8*NBYTES-1:0]   data_i,
    input  logic                  stb_i,
    input  logic                  xon_i,
    input  logic                  xoff_i,
    output logic                  rdy_o,
    output logic                  tx_o
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int YW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [YW-1:0] BYTE_LAST = YW'(NBYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_HOLD
    } state_t;

    state_t                r_state;
    logic [BW-1:0]         r_baud;
    logic [2:0]            r_bit_cnt;
    logic [YW-1:0]         r_byte_cnt;
    logic [8*NBYTES-1:0]   r_shift;
    logic                  r_paused;
    logic                  r_rdy;
    logic                  r_tx;

    state_t                w_state_next;
    logic [BW-1:0]         w_baud_next;
    logic [2:0]            w_bit_cnt_next;
    logic [YW-1:0]         w_byte_cnt_next;
    logic [8*NBYTES-1:0]   w_shift_next;
    logic                  w_paused_next;
    logic                  w_tx_next;
    logic                  w_rdy_next;
    logic                  w_bit_end;
    logic                  w_accept;

    assign w_bit_end = (r_baud == BAUD_LAST);
    assign w_accept  = stb_i && r_rdy;

    always_comb begin
        w_state_next    = r_state;
        w_baud_next     = w_bit_end ? '0 : r_baud + 1'b1;
        w_bit_cnt_next  = r_bit_cnt;
        w_byte_cnt_next = r_byte_cnt;
        w_shift_next    = r_shift;
        w_paused_next   = xoff_i ? 1'b1 : (xon_i ? 1'b0 : r_paused);

        case (r_state)
            S_IDLE: begin
                w_baud_next = '0;
                if (w_accept) begin
                    w_state_next    = S_START;
                    w_shift_next    = data_i;
                    w_byte_cnt_next = '0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_next   = S_DATA;
                    w_bit_cnt_next = '0;
                end
            end
            S_DATA: begin
                // The whole word shifts, so the next byte lands in [7:0] after 8 bits.
                if (w_bit_end) begin
                    w_shift_next   = r_shift >> 1;
                    w_bit_cnt_next = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_byte_cnt == BYTE_LAST) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_byte_cnt_next = r_byte_cnt + 1'b1;
                        w_state_next    = r_paused ? S_HOLD : S_START;
                    end
                end
            end
            S_HOLD: begin
                w_baud_next = '0;
                if (!r_paused) begin
                    w_state_next = S_START;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_baud_next  = '0;
            end
        endcase

        case (w_state_next)
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = w_shift_next[0];
            default: w_tx_next = 1'b1;
        endcase

        w_rdy_next = (w_state_next == S_IDLE) && !w_paused_next;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_baud     <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
            r_paused   <= 1'b0;
            r_rdy      <= 1'b1;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_baud     <= w_baud_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_byte_cnt <= w_byte_cnt_next;
            r_shift    <= w_shift_next;
            r_paused   <= w_paused_next;
            r_rdy      <= w_rdy_next;
            r_tx       <= w_tx_next;
        end
    end

    assign rdy_o = r_rdy;
    assign tx_o  = r_tx;

endmodule

// File: tb/tb_uart_tx_word.sv
// Bench for uart_tx_word: cycle-level line/ready reference built from 8N1 frames,
// plus directed byte decoding of captured line samples.
module tb_uart_tx_word;

    localparam int CPB   = 4;
    localparam int NB    = 4;
    localparam int W     = 8 * NB;
    localparam int FRAME = 10 * CPB;

    logic         clk  = 1'b0;
    logic         rst  = 1'b1;
    logic [W-1:0] data = '0;
    logic         stb  = 1'b0;
    logic         xon  = 1'b0;
    logic         xoff = 1'b0;
    logic         rdy;
    logic         tx;

    uart_tx_word #(.CLKS_PER_BIT(CPB), .NBYTES(NB)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .data_i (data),
        .stb_i  (stb),
        .xon_i  (xon),
        .xoff_i (xoff),
        .rdy_o  (rdy),
        .tx_o   (tx)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc_n  = 0;

    // Reference: expected line level per cycle, refilled one frame per byte.
    bit           m_line   = 1'b1;
    bit           m_rdy    = 1'b1;
    bit           m_paused = 1'b0;
    bit           m_busy   = 1'b0;
    bit           m_hold   = 1'b0;
    logic [W-1:0] m_word   = '0;
    int           m_idx    = 0;
    bit           m_q[$];

    bit cap_on = 1'b0;
    bit cap_q[$];

    task automatic load_byte(input int k);
        logic [7:0] b;
        bit lvl;
        b = m_word[8*k +: 8];
        m_q.delete();
        for (int i = 0; i < 10; i++) begin
            lvl = (i == 0) ? 1'b0 : ((i == 9) ? 1'b1 : b[i-1]);
            for (int c = 0; c < CPB; c++) m_q.push_back(lvl);
        end
    endtask

    task automatic model_edge();
        bit p_old;
        bit p_new;
        p_old = m_paused;
        if (rst) begin
            m_line = 1'b1; m_rdy = 1'b1; m_paused = 1'b0;
            m_busy = 1'b0; m_hold = 1'b0; m_q.delete();
            return;
        end
        p_new = xoff ? 1'b1 : (xon ? 1'b0 : p_old);
        if (stb && m_rdy) begin
            m_word = data; m_idx = 0; m_busy = 1'b1; m_hold = 1'b0;
            load_byte(0);
            m_line = m_q.pop_front();
        end else if (m_busy) begin
            if (m_hold) begin
                if (!p_old) begin
                    m_hold = 1'b0; m_idx++; load_byte(m_idx);
                    m_line = m_q.pop_front();
                end else begin
                    m_line = 1'b1;
                end
            end else if (m_q.size() != 0) begin
                m_line = m_q.pop_front();
            end else if (m_idx == NB - 1) begin
                m_busy = 1'b0; m_line = 1'b1;
            end else if (p_old) begin
                m_hold = 1'b1; m_line = 1'b1;
            end else begin
                m_idx++; load_byte(m_idx);
                m_line = m_q.pop_front();
            end
        end else begin
            m_line = 1'b1;
        end
        m_paused = p_new;
        m_rdy    = !m_busy && !p_new;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc_n, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        cyc_n++;
        checks++;
        assert (tx === m_line) else begin
            errors++;
            $error("FAIL tx_line cycle=%0d got=%b exp=%b", cyc_n, tx, m_line);
        end
        checks++;
        assert (rdy === m_rdy) else begin
            errors++;
            $error("FAIL rdy cycle=%0d got=%b exp=%b", cyc_n, rdy, m_rdy);
        end
        if (cap_on) cap_q.push_back(tx);
        stb = 1'b0; xon = 1'b0; xoff = 1'b0; rst = 1'b0;
        data = $urandom();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_rdy(input int budget, output int took);
        took = 0;
        while (rdy !== 1'b1 && took < budget) begin
            cyc();
            took++;
        end
        chk("rdy_timeout", {31'd0, rdy}, 32'd1);
    endtask

    task automatic check_decode(input string tag, input logic [W-1:0] w);
        logic [7:0] got;
        int base;
        if (cap_q.size() < NB * FRAME) begin
            chk({tag, "_capture_len"}, cap_q.size(), NB * FRAME);
            return;
        end
        for (int k = 0; k < NB; k++) begin
            base = k * FRAME;
            for (int b = 0; b < 8; b++) got[b] = cap_q[base + CPB * (1 + b) + CPB / 2];
            chk({tag, "_start"}, {31'd0, cap_q[base + CPB / 2]}, 32'd0);
            chk({tag, "_byte"}, {24'd0, got}, {24'd0, w[8*k +: 8]});
            chk({tag, "_stop"}, {31'd0, cap_q[base + 9 * CPB + CPB / 2]}, 32'd1);
        end
    endtask

    task automatic send_captured(input logic [W-1:0] w);
        cap_q.delete();
        cap_on = 1'b1;
        stb = 1'b1; data = w;
        cyc();
    endtask

    int took;

    initial begin
        // 1. reset and idle line
        rst = 1'b1; cyc();
        rst = 1'b1; cyc();
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_rdy", {31'd0, rdy}, 32'd1);
        run(100);

        // 2. single word: bytes, bit timing, ready latency
        send_captured(32'h12345678);
        chk("accept_tx_start", {31'd0, tx}, 32'd0);
        chk("accept_rdy_low", {31'd0, rdy}, 32'd0);
        wait_rdy(400, took);
        chk("word_latency", took, 10 * NB * CPB);
        cap_on = 1'b0;
        check_decode("w12345678", 32'h12345678);
        run(10);

        // 3. strobes while busy are ignored
        send_captured(32'hCAFEF00D);
        run(20);
        for (int i = 0; i < 5; i++) begin
            stb = 1'b1; data = 32'hDEADBEEF; cyc();
            run(7);
        end
        wait_rdy(400, took);
        cap_on = 1'b0;
        check_decode("wCAFEF00D", 32'hCAFEF00D);
        run(100);

        // 4. xoff during byte 1, hold 50 cycles, then xon
        stb = 1'b1; data = 32'hA5A55A5A; cyc();
        run(50);
        xoff = 1'b1; cyc();
        run(29);
        run(50);
        chk("hold_tx_high", {31'd0, tx}, 32'd1);
        chk("hold_rdy_low", {31'd0, rdy}, 32'd0);
        xon = 1'b1; cyc();
        wait_rdy(500, took);
        run(5);

        // 4b. xoff together with accepted strobe: first byte still goes out
        stb = 1'b1; xoff = 1'b1; data = 32'h0F1E2D3C; cyc();
        chk("xoff_stb_start", {31'd0, tx}, 32'd0);
        run(45);
        chk("xoff_stb_hold_tx", {31'd0, tx}, 32'd1);
        chk("xoff_stb_hold_rdy", {31'd0, rdy}, 32'd0);
        xon = 1'b1; cyc();
        wait_rdy(500, took);

        // 5. xon and xoff together in idle: XOFF wins, strobe ignored
        xon = 1'b1; xoff = 1'b1; cyc();
        chk("xon_xoff_rdy", {31'd0, rdy}, 32'd0);
        stb = 1'b1; data = 32'h55AA55AA; cyc();
        chk("paused_stb_ignored", {31'd0, tx}, 32'd1);
        run(20);
        xon = 1'b1; cyc();
        chk("xon_rdy_back", {31'd0, rdy}, 32'd1);

        // 6. reset in the middle of byte 2 data
        stb = 1'b1; data = 32'h9C3E71B5; cyc();
        run(95);
        rst = 1'b1; cyc();
        chk("abort_tx", {31'd0, tx}, 32'd1);
        chk("abort_rdy", {31'd0, rdy}, 32'd1);
        run(10);
        send_captured(32'h00000001);
        wait_rdy(400, took);
        chk("post_abort_latency", took, 10 * NB * CPB);
        cap_on = 1'b0;
        check_decode("w00000001", 32'h00000001);

        // 7. random strobes and flow-control pulses
        for (int i = 0; i < 3000; i++) begin
            stb  = ($urandom_range(0, 9) == 0);
            xoff = ($urandom_range(0, 149) == 0);
            xon  = ($urandom_range(0, 29) == 0);
            cyc();
        end
        xon = 1'b1; cyc();
        wait_rdy(1000, took);
        run(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
